// File: rtl/partition_write_arbiter.sv
// partition_write_arbiter: round-robin arbiter that funnels up to eight
// partition writers onto one Avalon-MM write master. A requester is only
// admitted while its partition_enables bit is set. The grant holder keeps
// the port for at most QUANTUM writes while anyone else is waiting.
module partition_write_arbiter #(
   parameter int N_PARTITIONS = 5,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 64,
   parameter int QUANTUM      = 4
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [N_PARTITIONS-1:0]          req_valid,
   output logic [N_PARTITIONS-1:0]          req_ready,
   input  logic [N_PARTITIONS*ADDR_W-1:0]   req_address,
   input  logic [N_PARTITIONS*DATA_W-1:0]   req_writedata,
   input  logic [N_PARTITIONS-1:0]          partition_enables,
   output logic [ADDR_W-1:0]                avm_address,
   output logic [DATA_W-1:0]                avm_writedata,
   output logic                             avm_write,
   input  logic                             avm_waitrequest,
   output logic [4:0]                       dbg_info
);

   localparam int              CNT_W = $clog2(QUANTUM) + 1;
   localparam logic [CNT_W-1:0] QUANT = CNT_W'(QUANTUM);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [3:0]       N4    = 4'(N_PARTITIONS);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          grant_q, grant_d;
   logic [2:0]          rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                write_q, write_d;

   logic [N_PARTITIONS-1:0] eligible, grant_mask, others;
   logic                    elig_grant;
   logic [3:0]              pick_all, pick_oth;
   logic                    accept, new_grant;
   logic [2:0]              acc_idx;
   logic [3:0]              acc_inc;

   // Returns {hit, index}: first set bit of vec at or above ptr, wrapping.
   // The request vector is rotated down by ptr so a plain lowest-bit search
   // gives the offset from ptr.
   function automatic logic [3:0] rr_pick(input logic [N_PARTITIONS-1:0] vec,
                                          input logic [2:0] ptr);
      logic [2*N_PARTITIONS-1:0] dbl;
      logic [N_PARTITIONS-1:0]   rot;
      logic [3:0]                off, sum;
      logic                      hit;
      dbl = {vec, vec};
      rot = N_PARTITIONS'(dbl >> ptr);
      off = 4'd0;
      hit = 1'b0;
      for (int j = N_PARTITIONS - 1; j >= 0; j--) begin
         if (rot[j]) begin
            off = 4'(j);
            hit = 1'b1;
         end
      end
      sum = {1'b0, ptr} + off;
      if (sum >= N4) sum = sum - N4;
      return {hit, sum[2:0]};
   endfunction

   // Eligibility and the two round-robin candidates (any / anyone but grant).
   always_comb begin
      eligible = req_valid & partition_enables;
      for (int i = 0; i < N_PARTITIONS; i++) grant_mask[i] = (grant_q == 3'(i));
      others     = eligible & ~grant_mask;
      elig_grant = |(eligible & grant_mask);
      pick_all   = rr_pick(eligible, rr_ptr_q);
      pick_oth   = rr_pick(others, rr_ptr_q);
   end

   // Next-state decision: who (if anyone) is accepted this cycle.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      count_d   = count_q;
      addr_d    = addr_q;
      data_d    = data_q;
      write_d   = write_q;
      accept    = 1'b0;
      new_grant = 1'b0;
      acc_idx   = grant_q;
      acc_inc   = 4'd0;
      req_ready = '0;

      case (state_q)
         IDLE: begin
            write_d = 1'b0;
            if (pick_all[3]) begin
               accept    = 1'b1;
               new_grant = 1'b1;
               acc_idx   = pick_all[2:0];
               count_d   = ONE;
            end
         end
         ISSUE: begin
            // Address/data hold while stalled; decisions only on completion.
            if (!avm_waitrequest) begin
               if (elig_grant && (count_q < QUANT)) begin
                  accept  = 1'b1;
                  count_d = count_q + ONE;
               end else if (pick_oth[3]) begin
                  accept    = 1'b1;
                  new_grant = 1'b1;
                  acc_idx   = pick_oth[2:0];
                  count_d   = ONE;
               end else if (elig_grant) begin
                  // Lone requester at its quantum: re-grant without a gap.
                  accept  = 1'b1;
                  count_d = ONE;
               end else begin
                  state_d = IDLE;
                  write_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         state_d = ISSUE;
         grant_d = acc_idx;
         write_d = 1'b1;
         for (int i = 0; i < N_PARTITIONS; i++) begin
            if (acc_idx == 3'(i)) begin
               addr_d       = req_address[i*ADDR_W +: ADDR_W];
               data_d       = req_writedata[i*DATA_W +: DATA_W];
               req_ready[i] = ~reset;
            end
         end
         if (new_grant) begin
            acc_inc  = {1'b0, acc_idx} + 4'd1;
            rr_ptr_d = (acc_inc == N4) ? 3'd0 : acc_inc[2:0];
         end
      end
   end

   // State and Avalon output registers; reset drops avm_write at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= 3'd0;
         rr_ptr_q <= 3'd0;
         count_q  <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         write_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         write_q  <= write_d;
      end
   end

   assign avm_address   = addr_q;
   assign avm_writedata = data_q;
   assign avm_write     = write_q;
   assign dbg_info      = {(state_q == ISSUE) & avm_waitrequest, state_q == ISSUE, grant_q};

endmodule
